// File: rtl/volatility_feed_ctrl_if.sv
// Top-of-book update channel from the order book into volatility_feed_ctrl.
// The master drives an update and the slave answers with ready.
interface volatility_feed_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_STOCKS = 4
);
   localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

   logic                  i_valid;
   logic                  o_ready;
   logic [SW-1:0]         i_stock_id;
   logic [DATA_WIDTH-1:0] i_best_bid;
   logic [DATA_WIDTH-1:0] i_best_ask;

   modport master (output i_valid, i_stock_id, i_best_bid, i_best_ask, input o_ready);
   modport slave  (input i_valid, i_stock_id, i_best_bid, i_best_ask, output o_ready);
endinterface

// File: rtl/volatility_feed_ctrl.sv
// Write-side controller for the per-stock mid-price history: queues updates and emits flat-address writes.
// Optional VOL_FEED_DEDUP_EN discards updates that repeat the last emitted {bid, ask} of their stock.
module volatility_feed_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int FP_WORD_SIZE = 64,
   parameter int BUFFER_SIZE  = 32,
   parameter int NUM_STOCKS   = 4,
   parameter int FIFO_DEPTH   = 4,
   localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
   localparam int AW = $clog2(NUM_STOCKS * BUFFER_SIZE),
   localparam int FW = $clog2(BUFFER_SIZE + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   volatility_feed_ctrl_if.slave   upd,
   input  logic                    i_clear,
   input  logic [SW-1:0]           i_clear_stock,
   output logic                    o_valid,
   output logic [AW-1:0]           o_write_address,
   output logic [SW-1:0]           o_stock_id,
   output logic [DATA_WIDTH-1:0]   o_best_bid,
   output logic [DATA_WIDTH-1:0]   o_best_ask,
   output logic [DATA_WIDTH-1:0]   o_buffer_size,
   output logic [FP_WORD_SIZE-1:0] o_buffer_size_reciprocal,
   output logic [FW-1:0]           o_fill,
   output logic                    o_buffer_full,
   output logic [15:0]             o_drop_count
);
   localparam int PW = $clog2(BUFFER_SIZE);
   localparam int QW = $clog2(FIFO_DEPTH);
   localparam int EW = SW + 2 * DATA_WIDTH;
   localparam logic [SW:0] NS_L = (SW+1)'(NUM_STOCKS);
   localparam logic [FP_WORD_SIZE-1:0] RECIP = FP_WORD_SIZE'((64'd1 << 32) / 64'(BUFFER_SIZE));

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + 17'(inc);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [FW-1:0] sat_fill(input logic [FW-1:0] f);
      return (f == FW'(BUFFER_SIZE)) ? f : f + FW'(1);
   endfunction

   // ---- stage p0: input queue, filtered at push ----
   logic [EW-1:0] mem_p0 [FIFO_DEPTH];
   logic [QW-1:0] wr_ptr_p0, rd_ptr_p0;
   logic [QW:0]   count_p0;
   logic          handshake, drop_in, drop_push, push, pop;

   assign upd.o_ready = (count_p0 != (QW+1)'(FIFO_DEPTH));
   assign handshake   = upd.i_valid && upd.o_ready;
   assign drop_in     = ({1'b0, upd.i_stock_id} >= NS_L) ||
                        ((upd.i_best_bid == '0) && (upd.i_best_ask == '0));
   assign drop_push   = handshake && drop_in;
   assign push        = handshake && !drop_in;
   assign pop         = (count_p0 != '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         count_p0  <= '0;
      end else begin
         if (push) wr_ptr_p0 <= wr_ptr_p0 + QW'(1);
         if (pop)  rd_ptr_p0 <= rd_ptr_p0 + QW'(1);
         case ({push, pop})
            2'b10:   count_p0 <= count_p0 + (QW+1)'(1);
            2'b01:   count_p0 <= count_p0 - (QW+1)'(1);
            default: count_p0 <= count_p0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_p0[wr_ptr_p0] <= {upd.i_stock_id, upd.i_best_bid, upd.i_best_ask};
   end

   logic [EW-1:0]         head;
   logic [SW-1:0]         h_id;
   logic [DATA_WIDTH-1:0] h_bid, h_ask;
   assign head  = mem_p0[rd_ptr_p0];
   assign h_id  = head[EW-1 -: SW];
   assign h_bid = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
   assign h_ask = head[DATA_WIDTH-1:0];

   // A same-cycle clear of the popped stock wins: the write sees cleared state.
   logic [PW-1:0] ptr_q  [NUM_STOCKS];
   logic [FW-1:0] fill_q [NUM_STOCKS];
   logic          clear_hit, dup, emit;
   logic [PW-1:0] eff_ptr, next_ptr;
   logic [FW-1:0] eff_fill, next_fill;

   assign clear_hit = i_clear && (i_clear_stock == h_id);
   assign eff_ptr   = clear_hit ? '0 : ptr_q[h_id];
   assign eff_fill  = clear_hit ? '0 : fill_q[h_id];
   assign next_ptr  = (eff_ptr == PW'(BUFFER_SIZE - 1)) ? '0 : eff_ptr + PW'(1);
   assign next_fill = sat_fill(eff_fill);
   assign emit      = pop && !dup;

`ifdef VOL_FEED_DEDUP_EN
   logic [DATA_WIDTH-1:0] last_bid_q [NUM_STOCKS];
   logic [DATA_WIDTH-1:0] last_ask_q [NUM_STOCKS];
   assign dup = pop && !clear_hit && (last_bid_q[h_id] == h_bid) && (last_ask_q[h_id] == h_ask);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            last_bid_q[s] <= '0;
            last_ask_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_clear && (i_clear_stock == SW'(s))) begin
               last_bid_q[s] <= '0;
               last_ask_q[s] <= '0;
            end
         end
         if (emit) begin
            last_bid_q[h_id] <= h_bid;
            last_ask_q[h_id] <= h_ask;
         end
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            ptr_q[s]  <= '0;
            fill_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_clear && (i_clear_stock == SW'(s))) begin
               ptr_q[s]  <= '0;
               fill_q[s] <= '0;
            end
         end
         if (emit) begin
            ptr_q[h_id]  <= next_ptr;
            fill_q[h_id] <= next_fill;
         end
      end
   end

   // ---- stage p1: output write register ----
   logic                  vld_p1;
   logic [AW-1:0]         addr_p1;
   logic [SW-1:0]         id_p1;
   logic [DATA_WIDTH-1:0] bid_p1, ask_p1;
   logic [FW-1:0]         fill_p1;
   logic                  full_p1;
   logic [15:0]           drops_p1;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p1   <= 1'b0;
         addr_p1  <= '0;
         id_p1    <= '0;
         bid_p1   <= '0;
         ask_p1   <= '0;
         fill_p1  <= '0;
         full_p1  <= 1'b0;
         drops_p1 <= '0;
      end else begin
         vld_p1   <= emit;
         drops_p1 <= sat_add16(drops_p1, {1'b0, drop_push} + {1'b0, dup});
         if (emit) begin
            addr_p1 <= AW'(h_id) * AW'(BUFFER_SIZE) + AW'(eff_ptr);
            id_p1   <= h_id;
            bid_p1  <= h_bid;
            ask_p1  <= h_ask;
            fill_p1 <= next_fill;
            full_p1 <= (next_fill == FW'(BUFFER_SIZE));
         end
      end
   end

   assign o_valid                  = vld_p1;
   assign o_write_address          = addr_p1;
   assign o_stock_id               = id_p1;
   assign o_best_bid               = bid_p1;
   assign o_best_ask               = ask_p1;
   assign o_fill                   = fill_p1;
   assign o_buffer_full            = full_p1;
   assign o_drop_count             = drops_p1;
   assign o_buffer_size            = DATA_WIDTH'(BUFFER_SIZE);
   assign o_buffer_size_reciprocal = RECIP;
endmodule

// File: tb/tb_volatility_feed_ctrl.sv
// Directed bench for volatility_feed_ctrl: vector table plus multi-cycle sequences.
// A second 5-stock instance exercises out-of-range stock ids, which a 2-bit id cannot carry.
module tb_volatility_feed_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance: 4 stocks x 32 deep
   volatility_feed_ctrl_if #(.DATA_WIDTH(32), .NUM_STOCKS(4)) u ();
   logic        clr;
   logic [1:0]  clr_stk;
   logic        o_valid, o_full;
   logic [6:0]  o_addr;
   logic [1:0]  o_id;
   logic [31:0] o_bid, o_ask, o_bsz;
   logic [63:0] o_recip;
   logic [5:0]  o_fill;
   logic [15:0] o_drop;

   volatility_feed_ctrl #(.DATA_WIDTH(32), .FP_WORD_SIZE(64), .BUFFER_SIZE(32),
                          .NUM_STOCKS(4), .FIFO_DEPTH(4)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .upd(u), .i_clear(clr), .i_clear_stock(clr_stk),
      .o_valid(o_valid), .o_write_address(o_addr), .o_stock_id(o_id),
      .o_best_bid(o_bid), .o_best_ask(o_ask), .o_buffer_size(o_bsz),
      .o_buffer_size_reciprocal(o_recip), .o_fill(o_fill), .o_buffer_full(o_full),
      .o_drop_count(o_drop));

   // second instance: 5 stocks, 3-bit id
   volatility_feed_ctrl_if #(.DATA_WIDTH(32), .NUM_STOCKS(5)) ub ();
   logic        b_clr;
   logic [2:0]  b_clr_stk;
   logic        b_valid, b_full;
   logic [7:0]  b_addr;
   logic [2:0]  b_id;
   logic [31:0] b_bid, b_ask, b_bsz;
   logic [63:0] b_recip;
   logic [5:0]  b_fill;
   logic [15:0] b_drop;

   volatility_feed_ctrl #(.DATA_WIDTH(32), .FP_WORD_SIZE(64), .BUFFER_SIZE(32),
                          .NUM_STOCKS(5), .FIFO_DEPTH(4)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .upd(ub), .i_clear(b_clr), .i_clear_stock(b_clr_stk),
      .o_valid(b_valid), .o_write_address(b_addr), .o_stock_id(b_id),
      .o_best_bid(b_bid), .o_best_ask(b_ask), .o_buffer_size(b_bsz),
      .o_buffer_size_reciprocal(b_recip), .o_fill(b_fill), .o_buffer_full(b_full),
      .o_drop_count(b_drop));

   typedef struct {
      logic [6:0]  addr;
      logic [1:0]  id;
      logic [31:0] bid;
      logic [31:0] ask;
      logic [5:0]  fill;
      logic        full;
      int          cyc;
   } wr_t;
   wr_t wq[$];

   int ready_low = 0;
   int b_writes = 0;
   logic [7:0] b_last_addr = '0;
   logic [5:0] b_last_fill = '0;

   always @(negedge clk) begin
      if (o_valid === 1'b1) begin
         wr_t w;
         w.addr = o_addr; w.id = o_id; w.bid = o_bid; w.ask = o_ask;
         w.fill = o_fill; w.full = o_full; w.cyc = cyc;
         wq.push_back(w);
      end
      if (u.o_ready !== 1'b1) ready_low++;
      if (b_valid === 1'b1) begin
         b_writes++;
         b_last_addr = b_addr;
         b_last_fill = b_fill;
      end
   end

   typedef struct {
      logic [1:0]  id;
      logic [31:0] bid;
      logic [31:0] ask;
      logic [6:0]  addr;
      logic [5:0]  fill;
   } vec_t;
   vec_t vt [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] id, input logic [31:0] b, input logic [31:0] a,
                       output int acc);
      int t;
      u.i_valid = 1'b1; u.i_stock_id = id; u.i_best_bid = b; u.i_best_ask = a;
      t = 0;
      while (u.o_ready !== 1'b1 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 20) chk("ready_timeout", 64'(u.o_ready), 64'd1);
      @(posedge clk);
      #1;
      acc = cyc;
      u.i_valid = 1'b0;
   endtask

   task automatic wait_writes(input int n, input string name);
      int t;
      t = 0;
      while (wq.size() < n && t < 80) begin
         @(posedge clk); #1; t++;
      end
      idle(3);
      chk({name, "_count"}, 64'(wq.size()), 64'(n));
   endtask

   int acc;
   int exp_n;
   logic [6:0] exp_addr [3];
   logic [31:0] exp_ask [3];
   logic [15:0] exp_drop;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{2'd2, 32'd100, 32'd102, 7'd64, 6'd1};
      vt[1] = '{2'd2, 32'd101, 32'd103, 7'd65, 6'd2};
      vt[2] = '{2'd0, 32'd7,   32'd9,   7'd0,  6'd1};
      vt[3] = '{2'd3, 32'd0,   32'd5,   7'd96, 6'd1};
      vt[4] = '{2'd1, 32'd5,   32'd0,   7'd32, 6'd1};
      vt[5] = '{2'd2, 32'd100, 32'd102, 7'd66, 6'd3};

      u.i_valid = 1'b0; u.i_stock_id = '0; u.i_best_bid = '0; u.i_best_ask = '0;
      ub.i_valid = 1'b0; ub.i_stock_id = '0; ub.i_best_bid = '0; ub.i_best_ask = '0;
      clr = 1'b0; clr_stk = '0; b_clr = 1'b0; b_clr_stk = '0;
      exp_drop = 16'd0;

      // reset state
      idle(3);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_ready", 64'(u.o_ready), 64'd1);
      chk("rst_addr", 64'(o_addr), 64'd0);
      chk("rst_fill", 64'(o_fill), 64'd0);
      chk("rst_full", 64'(o_full), 64'd0);
      chk("rst_drop", 64'(o_drop), 64'd0);
      chk("rst_bsz", 64'(o_bsz), 64'd32);
      chk("rst_recip", o_recip, 64'h0000_0000_0800_0000);
      @(negedge clk) rst_n = 1'b1;
      idle(2);

      // isolated single updates from the vector table
      for (int i = 0; i < 6; i++) begin
         wq.delete();
         send(vt[i].id, vt[i].bid, vt[i].ask, acc);
         chk($sformatf("vec%0d_valid_at_accept", i), 64'(o_valid), 64'd0);
         wait_writes(1, $sformatf("vec%0d", i));
         if (wq.size() > 0) begin
            chk($sformatf("vec%0d_addr", i), 64'(wq[0].addr), 64'(vt[i].addr));
            chk($sformatf("vec%0d_fill", i), 64'(wq[0].fill), 64'(vt[i].fill));
            chk($sformatf("vec%0d_full", i), 64'(wq[0].full), 64'd0);
            chk($sformatf("vec%0d_id", i), 64'(wq[0].id), 64'(vt[i].id));
            chk($sformatf("vec%0d_bid", i), 64'(wq[0].bid), 64'(vt[i].bid));
            chk($sformatf("vec%0d_ask", i), 64'(wq[0].ask), 64'(vt[i].ask));
            chk($sformatf("vec%0d_latency", i), 64'(wq[0].cyc - acc), 64'd1);
         end
         chk($sformatf("vec%0d_hold_valid", i), 64'(o_valid), 64'd0);
         chk($sformatf("vec%0d_hold_addr", i), 64'(o_addr), 64'(vt[i].addr));
         chk($sformatf("vec%0d_hold_fill", i), 64'(o_fill), 64'(vt[i].fill));
      end

      // 33 back-to-back writes to a freshly cleared stock 1: wrap and fill saturation
      clr = 1'b1; clr_stk = 2'd1;
      idle(1);
      clr = 1'b0;
      wq.delete();
      for (int i = 0; i < 33; i++) send(2'd1, 32'(1000 + i), 32'(2000 + i), acc);
      wait_writes(33, "wrap");
      for (int i = 0; i < wq.size() && i < 33; i++) begin
         chk($sformatf("wrap%0d_addr", i), 64'(wq[i].addr), 64'(32 + (i % 32)));
         chk($sformatf("wrap%0d_fill", i), 64'(wq[i].fill), 64'((i < 32) ? i + 1 : 32));
         chk($sformatf("wrap%0d_full", i), 64'(wq[i].full), 64'((i >= 31) ? 1 : 0));
         chk($sformatf("wrap%0d_bid", i), 64'(wq[i].bid), 64'(1000 + i));
      end
      chk("wrap_hold_full", 64'(o_full), 64'd1);

      // burst of 6 to stock 0 (ptr 1, fill 1) with continuous popping
      wq.delete();
      ready_low = 0;
      for (int i = 0; i < 6; i++) send(2'd0, 32'(300 + i), 32'(400 + i), acc);
      wait_writes(6, "burst");
      chk("burst_ready_low", 64'(ready_low), 64'd0);
      for (int i = 0; i < wq.size() && i < 6; i++) begin
         chk($sformatf("burst%0d_addr", i), 64'(wq[i].addr), 64'(1 + i));
         chk($sformatf("burst%0d_bid", i), 64'(wq[i].bid), 64'(300 + i));
         chk($sformatf("burst%0d_fill", i), 64'(wq[i].fill), 64'(2 + i));
      end

      // zero-price updates are discarded at push
      wq.delete();
      send(2'd2, 32'd0, 32'd0, acc);
      send(2'd3, 32'd0, 32'd0, acc);
      idle(5);
      exp_drop = 16'd2;
      chk("zero_writes", 64'(wq.size()), 64'd0);
      chk("zero_drop", 64'(o_drop), 64'(exp_drop));

      // out-of-range ids on the 5-stock instance, then a zero pair, then a valid id 4
      ub.i_valid = 1'b1; ub.i_stock_id = 3'd5; ub.i_best_bid = 32'd10; ub.i_best_ask = 32'd11;
      idle(1);
      ub.i_stock_id = 3'd7;
      idle(1);
      ub.i_stock_id = 3'd2; ub.i_best_bid = 32'd0; ub.i_best_ask = 32'd0;
      idle(1);
      ub.i_stock_id = 3'd4; ub.i_best_bid = 32'd10; ub.i_best_ask = 32'd11;
      idle(1);
      ub.i_valid = 1'b0;
      idle(4);
      chk("oor_drop", 64'(b_drop), 64'd3);
      chk("oor_writes", 64'(b_writes), 64'd1);
      chk("oor_addr", 64'(b_last_addr), 64'd128);
      chk("oor_fill", 64'(b_last_fill), 64'd1);

      // clear beats a same-cycle pop of the same stock
      clr = 1'b1; clr_stk = 2'd0;
      idle(1);
      clr = 1'b0;
      wq.delete();
      for (int i = 0; i < 10; i++) send(2'd0, 32'(500 + i), 32'(550 + i), acc);
      wait_writes(10, "pre_clear");
      if (wq.size() >= 10) begin
         chk("pre_clear_addr", 64'(wq[9].addr), 64'd9);
         chk("pre_clear_fill", 64'(wq[9].fill), 64'd10);
      end
      wq.delete();
      send(2'd0, 32'd600, 32'd601, acc);
      clr = 1'b1; clr_stk = 2'd0;
      idle(1);
      clr = 1'b0;
      wait_writes(1, "clr_pop");
      if (wq.size() > 0) begin
         chk("clr_pop_addr", 64'(wq[0].addr), 64'd0);
         chk("clr_pop_fill", 64'(wq[0].fill), 64'd1);
      end
      wq.delete();
      send(2'd0, 32'd602, 32'd603, acc);
      wait_writes(1, "post_clr");
      if (wq.size() > 0) begin
         chk("post_clr_addr", 64'(wq[0].addr), 64'd1);
         chk("post_clr_fill", 64'(wq[0].fill), 64'd2);
      end

      // repeated price pair on stock 3
`ifdef VOL_FEED_DEDUP_EN
      exp_n = 2;
      exp_addr[0] = 7'd96; exp_addr[1] = 7'd97; exp_addr[2] = 7'd0;
      exp_ask[0] = 32'd52; exp_ask[1] = 32'd53; exp_ask[2] = 32'd0;
      exp_drop = 16'd3;
`else
      exp_n = 3;
      exp_addr[0] = 7'd96; exp_addr[1] = 7'd97; exp_addr[2] = 7'd98;
      exp_ask[0] = 32'd52; exp_ask[1] = 32'd52; exp_ask[2] = 32'd53;
      exp_drop = 16'd2;
`endif
      clr = 1'b1; clr_stk = 2'd3;
      idle(1);
      clr = 1'b0;
      wq.delete();
      send(2'd3, 32'd50, 32'd52, acc);
      send(2'd3, 32'd50, 32'd52, acc);
      send(2'd3, 32'd50, 32'd53, acc);
      idle(4);
      wait_writes(exp_n, "dedup");
      for (int i = 0; i < wq.size() && i < exp_n; i++) begin
         chk($sformatf("dedup%0d_addr", i), 64'(wq[i].addr), 64'(exp_addr[i]));
         chk($sformatf("dedup%0d_ask", i), 64'(wq[i].ask), 64'(exp_ask[i]));
      end
      chk("dedup_drop", 64'(o_drop), 64'(exp_drop));

      // asynchronous reset mid-burst drops queued entries and pointer state
      send(2'd2, 32'd700, 32'd701, acc);
      send(2'd2, 32'd702, 32'd703, acc);
      send(2'd2, 32'd704, 32'd705, acc);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_fill", 64'(o_fill), 64'd0);
      chk("mid_rst_addr", 64'(o_addr), 64'd0);
      chk("mid_rst_drop", 64'(o_drop), 64'd0);
      chk("mid_rst_ready", 64'(u.o_ready), 64'd1);
      idle(2);
      @(negedge clk) rst_n = 1'b1;
      idle(1);
      wq.delete();
      idle(3);
      chk("mid_rst_stale", 64'(wq.size()), 64'd0);
      send(2'd2, 32'd800, 32'd801, acc);
      wait_writes(1, "after_rst");
      if (wq.size() > 0) begin
         chk("after_rst_addr", 64'(wq[0].addr), 64'd64);
         chk("after_rst_fill", 64'(wq[0].fill), 64'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
